// File: rtl/pulse_capture_pkg.sv
// Shared state encoding and saturation helper for the pulse_capture block.
package pulse_capture_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARMED   = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARMED   = ST_ARMED,
    MEASURE = ST_MEASURE
  } state_t;

  // Largest value an n-bit counter can hold.
  function automatic int unsigned sat_max(input int unsigned n);
    return (n >= 32) ? 32'hFFFF_FFFF : (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_edge_det.sv
// Qualifies meas_in and flags its rising edge. With PULSE_CAPTURE_SYNC_EN
// defined, meas_in first passes through a 2-flop synchronizer.
module pulse_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic meas_in,
  output logic level,
  output logic rise
);

  logic meas_prev;

`ifdef PULSE_CAPTURE_SYNC_EN
  logic sync1, sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= meas_in;
      sync2 <= sync1;
    end
  end

  assign level = sync2;
`else
  assign level = meas_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) meas_prev <= 1'b0;
    else        meas_prev <= level;
  end

  assign rise = level & ~meas_prev;

endmodule

// File: rtl/pulse_capture.sv
// Measures the high time of meas_in in clk cycles after being armed.
// Optional input synchronizer: define PULSE_CAPTURE_SYNC_EN.
module pulse_capture
  import pulse_capture_pkg::*;
#(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         arm,
  input  logic         abort,
  input  logic         meas_in,
  input  logic [N-1:0] cmp_val,
  output logic [N-1:0] cnt_val,
  output logic         valid,
  output logic         too_long,
  output logic         overflow,
  output logic         busy
);

  localparam logic [N-1:0] CNT_MAX = N'(sat_max(N));
  localparam logic [N-1:0] CNT_ONE = N'(1);

  state_t       state, state_nxt;
  logic [N-1:0] count;
  logic         sat_flag;
  logic         level, rise;
  logic         publish;

  pulse_edge_det u_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .meas_in (meas_in),
    .level   (level),
    .rise    (rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // abort dominates every other event in the cycle.
  always_comb begin
    state_nxt = state;
    publish   = 1'b0;
    unique case (state)
      IDLE:    if (arm && !abort) state_nxt = ARMED;
      ARMED:   if (abort) state_nxt = IDLE;
               else if (rise) state_nxt = MEASURE;
      MEASURE: if (abort) state_nxt = IDLE;
               else if (!level) begin
                 state_nxt = IDLE;
                 publish   = 1'b1;
               end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      sat_flag <= 1'b0;
    end else if (!abort) begin
      unique case (state)
        IDLE: if (arm) begin
          count    <= '0;
          sat_flag <= 1'b0;
        end
        ARMED: if (rise) begin
          count    <= CNT_ONE;
          sat_flag <= (CNT_ONE == CNT_MAX);
        end
        MEASURE: if (level && count != CNT_MAX) begin
          count <= count + CNT_ONE;
          if (count == CNT_MAX - CNT_ONE) sat_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers hold until the next publish; aborts leave them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_val  <= '0;
      valid    <= 1'b0;
      too_long <= 1'b0;
      overflow <= 1'b0;
    end else begin
      valid <= publish;
      if (publish) begin
        cnt_val  <= count;
        too_long <= (count > cmp_val);
        overflow <= sat_flag;
      end
    end
  end

  assign busy = (state == ARMED) || (state == MEASURE);

endmodule

// File: tb/tb_pulse_capture.sv
// Directed self-checking bench for pulse_capture (N=10 and N=4 instances
// share one stimulus stream).
module tb_pulse_capture;

`ifdef PULSE_CAPTURE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, arm, abort, meas_in;
  logic [9:0] cmp_val;
  logic [3:0] cmp4;
  logic [9:0] cnt10;
  logic [3:0] cnt4;
  logic       valid10, tl10, ov10, busy10;
  logic       valid4, tl4, ov4, busy4;

  int n_chk  = 0;
  int n_fail = 0;
  logic vseen;

  assign cmp4 = cmp_val[3:0];

  always #5 clk = ~clk;

  pulse_capture #(.N(10)) u10 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .meas_in(meas_in),
    .cmp_val(cmp_val), .cnt_val(cnt10), .valid(valid10), .too_long(tl10),
    .overflow(ov10), .busy(busy10)
  );

  pulse_capture #(.N(4)) u4 (
    .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .meas_in(meas_in),
    .cmp_val(cmp4), .cnt_val(cnt4), .valid(valid4), .too_long(tl4),
    .overflow(ov4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Idle cycles that also record any stray valid.
  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (valid10 || valid4) vseen = 1'b1;
    end
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("busy_after_arm", busy10, 1);
  endtask

  // Drive a pulse of len cycles and wait for the publish strobe.
  task automatic pulse(input int len);
    int d;
    meas_in = 1'b1;
    repeat (len) tick();
    meas_in = 1'b0;
    d = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      d++;
      if (valid10) break;
    end
    chk("valid_latency", d, 1 + LAT);
    chk("valid4_same_cycle", valid4, 1);
    chk("busy_at_valid", busy10, 0);
    tick();
    chk("valid_one_cycle", valid10, 0);
  endtask

  initial begin
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0; meas_in = 1'b0; cmp_val = 10'd10;
    vseen = 1'b0;
    tick(); tick();
    chk("rst_cnt", cnt10, 0);
    chk("rst_valid", valid10, 0);
    chk("rst_too_long", tl10, 0);
    chk("rst_overflow", ov10, 0);
    chk("rst_busy", busy10, 0);
    rst_n = 1'b1;
    idle_ticks(2);

    // Basic 7-cycle pulse
    do_arm();
    pulse(7);
    chk("basic_cnt", cnt10, 7);
    chk("basic_too_long", tl10, 0);
    chk("basic_overflow", ov10, 0);
    chk("basic_busy", busy10, 0);
    idle_ticks(4);

    // Threshold
    cmp_val = 10'd5;
    do_arm();
    pulse(7);
    chk("thr_cnt", cnt10, 7);
    chk("thr_too_long", tl10, 1);
    idle_ticks(4);
    do_arm();
    pulse(3);
    chk("thr2_cnt", cnt10, 3);
    chk("thr2_too_long", tl10, 0);
    idle_ticks(4);

    // Saturation on the 4-bit instance
    cmp_val = 10'd10;
    do_arm();
    pulse(20);
    chk("sat_cnt4", cnt4, 15);
    chk("sat_ov4", ov4, 1);
    chk("sat_tl4", tl4, 1);
    chk("sat_cnt10", cnt10, 20);
    chk("sat_ov10", ov10, 0);
    chk("sat_tl10", tl10, 1);
    idle_ticks(4);
    do_arm();
    pulse(2);
    chk("sat2_cnt4", cnt4, 2);
    chk("sat2_ov4", ov4, 0);
    idle_ticks(4);

    // Already high at arm: first pulse must not be counted
    cmp_val = 10'd2;
    vseen = 1'b0;
    meas_in = 1'b1;
    idle_ticks(3);
    do_arm();
    idle_ticks(3);
    meas_in = 1'b0;
    idle_ticks(3);
    chk("prehigh_no_valid", vseen, 0);
    chk("prehigh_still_busy", busy10, 1);
    pulse(4);
    chk("prehigh_cnt", cnt10, 4);
    chk("prehigh_too_long", tl10, 1);
    idle_ticks(4);

    // Abort 3 cycles into MEASURE
    vseen = 1'b0;
    do_arm();
    meas_in = 1'b1;
    repeat (3 + LAT) tick();
    chk("abort_busy_before", busy10, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy10, 0);
    meas_in = 1'b0;
    idle_ticks(6);
    chk("abort_no_valid", vseen, 0);
    chk("abort_cnt_kept", cnt10, 4);
    chk("abort_tl_kept", tl10, 1);

    // Arm ignored while busy: a second arm must not restart the wait
    do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
    pulse(5);
    chk("rearm_cnt", cnt10, 5);
    idle_ticks(4);

    // Asynchronous reset mid-measure
    do_arm();
    meas_in = 1'b1;
    repeat (4 + LAT) tick();
    chk("pre_rst_busy", busy10, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", cnt10, 0);
    chk("arst_too_long", tl10, 0);
    chk("arst_overflow", ov10, 0);
    chk("arst_busy", busy10, 0);
    chk("arst_valid", valid10, 0);
    tick(); tick();
    rst_n = 1'b1;
    meas_in = 1'b0;
    vseen = 1'b0;
    idle_ticks(6);
    chk("post_rst_no_valid", vseen, 0);
    chk("post_rst_busy", busy10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
